instr_fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Takes the current `pc` and issues in-order read requests to instruction memory. Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Generates `pc_advance` so the PC moves only when a fetch is accepted.
- Discards all buffered and in-flight instructions on a taken branch (`flush`).

---
 rtl/instr_fetch_queue.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order fetches at pc_in, tags each request
// with its PC, buffers returned words in a small FIFO and hands them to decode
// over valid/ready. A flush empties the FIFO and drops every in-flight response.
module instr_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        misaligned,
    output logic        resp_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW:0]   DEPTH_S   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
    localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUT - 1);

    // FIFO storage (data words and their PCs) and in-order tag queue
    logic [31:0]   fifo_instr_reg [DEPTH];
    logic [31:0]   fifo_pc_reg    [DEPTH];
    logic [31:0]   tag_reg        [MAX_OUT];

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] fifo_count_reg, fifo_count_next;
    logic [TW-1:0] tag_head_reg, tag_head_next;
    logic [TW-1:0] tag_tail_reg, tag_tail_next;
    logic [CW-1:0] out_count_reg, out_count_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic          resp_err_reg, resp_err_next;

    logic [CW:0]   credit_sum;
    logic          issue;
    logic          resp_ok;
    logic          resp_spurious;
    logic          keep_word;
    logic          pop;

    // Issue gating, response classification and decode-side view of the head
    always_comb begin
        misaligned    = |pc_in[1:0];
        credit_sum    = {1'b0, fifo_count_reg} + {1'b0, out_count_reg};
        // FIFO space is reserved at issue time, so responses can never overflow.
        // Requests are also held low while reset is asserted.
        imem_req      = !rst && !flush && !misaligned &&
                        (credit_sum < DEPTH_S) && (out_count_reg < MAX_OUT_C);
        imem_addr     = pc_in;
        issue         = imem_req && imem_gnt;
        pc_advance    = issue;
        resp_ok       = imem_rvalid && (out_count_reg != '0);
        resp_spurious = imem_rvalid && (out_count_reg == '0);
        // Words owed to a flushed path, or arriving in the flush cycle, are dropped
        keep_word     = resp_ok && (discard_reg == '0) && !flush;
        id_valid      = (fifo_count_reg != '0);
        pop           = id_valid && id_ready && !flush;
        id_instr      = id_valid ? fifo_instr_reg[head_reg] : '0;
        id_pc         = id_valid ? fifo_pc_reg[head_reg]    : '0;
        resp_err      = resp_err_reg;
    end

    // Next-state for pointers, counts, discard credit and the sticky error
    always_comb begin
        head_next       = head_reg;
        tail_next       = tail_reg;
        fifo_count_next = fifo_count_reg;
        tag_head_next   = tag_head_reg;
        tag_tail_next   = tag_tail_reg;
        out_count_next  = out_count_reg;
        discard_next    = discard_reg;
        resp_err_next   = resp_err_reg;

        if (issue)
            tag_tail_next = (tag_tail_reg == TAG_LAST) ? '0 : tag_tail_reg + TW'(1);
        if (resp_ok)
            tag_head_next = (tag_head_reg == TAG_LAST) ? '0 : tag_head_reg + TW'(1);

        case ({issue, resp_ok})
            2'b10:   out_count_next = out_count_reg + CW'(1);
            2'b01:   out_count_next = out_count_reg - CW'(1);
            default: out_count_next = out_count_reg;
        endcase

        if (resp_spurious)
            resp_err_next = 1'b1;

        if (flush) begin
            // Everything still in flight after this edge belongs to the dead path
            head_next       = '0;
            tail_next       = '0;
            fifo_count_next = '0;
            discard_next    = resp_ok ? out_count_reg - CW'(1) : out_count_reg;
        end else begin
            if (resp_ok && (discard_reg != '0))
                discard_next = discard_reg - CW'(1);
            if (keep_word)
                tail_next = tail_reg + PW'(1);
            if (pop)
                head_next = head_reg + PW'(1);
            case ({keep_word, pop})
                2'b10:   fifo_count_next = fifo_count_reg + CW'(1);
                2'b01:   fifo_count_next = fifo_count_reg - CW'(1);
                default: fifo_count_next = fifo_count_reg;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            fifo_count_reg <= '0;
            tag_head_reg   <= '0;
            tag_tail_reg   <= '0;
            out_count_reg  <= '0;
            discard_reg    <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            fifo_count_reg <= fifo_count_next;
            tag_head_reg   <= tag_head_next;
            tag_tail_reg   <= tag_tail_next;
            out_count_reg  <= out_count_next;
            discard_reg    <= discard_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    // Storage writes: tag on accepted request, {word, tag} on kept response
    always_ff @(posedge clk) begin
        if (!rst && issue)
            tag_reg[tag_tail_reg] <= pc_in;
        if (!rst && keep_word) begin
            fifo_instr_reg[tail_reg] <= imem_rdata;
            fifo_pc_reg[tail_reg]    <= tag_reg[tag_head_reg];
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order fixed-latency memory model.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        misaligned;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model state
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc = 0;
    int          lat = 1;
    int          acc_count = 0;
    logic        force_rvalid = 1'b0;
    logic        auto_pc = 1'b0;
    logic        last_req, last_adv;
    logic [31:0] last_addr;

    instr_fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_advance(pc_advance),
        .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .misaligned(misaligned), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock: sample at negedge, drive memory response, return #1 after posedge
    task automatic step();
        logic acc;
        @(negedge clk);
        last_req  = imem_req;
        last_adv  = pc_advance;
        last_addr = imem_addr;
        acc = imem_req && imem_gnt;
        if (id_valid && id_ready && !flush && !rst)
            $display("decode: pc=%08h instr=%08h", id_pc, id_instr);
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mk_instr(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rvalid = force_rvalid;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        if (acc) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
            acc_count++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (auto_pc && acc)
            pc_in = pc_in + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        q_addr.delete();
        q_due.delete();
        acc_count = 0;
        force_rvalid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; imem_gnt = 1'b1; id_ready = 1'b0;
        pc_in = 32'h0; imem_rvalid = 1'b0; imem_rdata = '0;
        step();
        step();
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
        n_cmp++; if (pc_advance !== 1'b0) begin n_bad++; $display("FAIL reset_pc_advance got %b want 0", pc_advance); end
        n_cmp++; if (id_instr !== 32'h0) begin n_bad++; $display("FAIL reset_id_instr got %h want 0", id_instr); end
        n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b1; auto_pc = 1'b1; pc_in = 32'h0;
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL stream_c0_valid got %b want 0", id_valid); end
        step();
        n_cmp++; if (last_adv !== 1'b1) begin n_bad++; $display("FAIL stream_adv0 got %b want 1", last_adv); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL stream_c1_valid got %b want 0", id_valid); end
        step();
        n_cmp++; if (last_adv !== 1'b1) begin n_bad++; $display("FAIL stream_adv1 got %b want 1", last_adv); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", k, id_valid); end
            n_cmp++; if (id_pc !== 32'(4 * k)) begin n_bad++; $display("FAIL stream_pc[%0d] got %h want %h", k, id_pc, 32'(4 * k)); end
            n_cmp++; if (id_instr !== mk_instr(32'(4 * k))) begin n_bad++; $display("FAIL stream_instr[%0d] got %h want %h", k, id_instr, mk_instr(32'(4 * k))); end
            step();
            n_cmp++; if (last_adv !== 1'b1) begin n_bad++; $display("FAIL stream_adv[%0d] got %b want 1", k, last_adv); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b0; auto_pc = 1'b1; pc_in = 32'h0;
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (acc_count != 4) begin n_bad++; $display("FAIL bp_accepts got %0d want 4", acc_count); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_full got %b want 0", imem_req); end
        n_cmp++; if (pc_advance !== 1'b0) begin n_bad++; $display("FAIL bp_adv_full got %b want 0", pc_advance); end
        n_cmp++; if (pc_in !== 32'h10) begin n_bad++; $display("FAIL bp_pc got %h want 10", pc_in); end
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain_valid[%0d] got %b want 1", i, id_valid); end
            n_cmp++; if (id_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_drain_pc[%0d] got %h want %h", i, id_pc, 32'(4 * i)); end
            n_cmp++; if (id_instr !== mk_instr(32'(4 * i))) begin n_bad++; $display("FAIL bp_drain_instr[%0d] got %h want %h", i, id_instr, mk_instr(32'(4 * i))); end
            step();
        end
        n_cmp++; if (acc_count != 9) begin n_bad++; $display("FAIL bp_resume_accepts got %0d want 9", acc_count); end
    endtask

    task automatic test_flush();
        int waited;
        do_reset();
        lat = 3; imem_gnt = 1'b1; id_ready = 1'b0; auto_pc = 1'b1; pc_in = 32'h0;
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_bad++; $display("FAIL fl_pre_head got v=%b pc=%h want v=1 pc=0", id_valid, id_pc); end
        n_cmp++; if (q_due.size() != 2) begin n_bad++; $display("FAIL fl_pre_inflight got %0d want 2", q_due.size()); end
        flush = 1'b1;
        pc_in = 32'h40;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin n_bad++; $display("FAIL fl_cycle_req got req=%b adv=%b want 0 0", imem_req, pc_advance); end
        step();
        flush = 1'b0;
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL fl_next_valid got %b want 0", id_valid); end
        n_cmp++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin n_bad++; $display("FAIL fl_next_data got pc=%h instr=%h want 0 0", id_pc, id_instr); end
        waited = 0;
        while (id_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_cmp++; if (waited != 5) begin n_bad++; $display("FAIL fl_wait_cycles got %0d want 5", waited); end
        n_cmp++; if (id_pc !== 32'h40) begin n_bad++; $display("FAIL fl_first_pc got %h want 40", id_pc); end
        n_cmp++; if (id_instr !== mk_instr(32'h40)) begin n_bad++; $display("FAIL fl_first_instr got %h want %h", id_instr, mk_instr(32'h40)); end
        id_ready = 1'b1;
        step();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h44) begin n_bad++; $display("FAIL fl_second_pc got v=%b pc=%h want v=1 pc=44", id_valid, id_pc); end
    endtask

    task automatic test_grant_stall();
        do_reset();
        lat = 1; imem_gnt = 1'b0; id_ready = 1'b1; auto_pc = 1'b1; pc_in = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (last_req !== 1'b1) begin n_bad++; $display("FAIL gs_req[%0d] got %b want 1", i, last_req); end
            n_cmp++; if (last_adv !== 1'b0) begin n_bad++; $display("FAIL gs_adv[%0d] got %b want 0", i, last_adv); end
            n_cmp++; if (last_addr !== 32'h10) begin n_bad++; $display("FAIL gs_addr[%0d] got %h want 10", i, last_addr); end
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        n_cmp++; if (last_adv !== 1'b1) begin n_bad++; $display("FAIL gs_grant_adv got %b want 1", last_adv); end
        step();
        n_cmp++; if (acc_count != 1) begin n_bad++; $display("FAIL gs_single_fetch got %0d want 1", acc_count); end
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h10) begin n_bad++; $display("FAIL gs_head got v=%b pc=%h want v=1 pc=10", id_valid, id_pc); end
    endtask

    task automatic test_errors();
        do_reset();
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b1; auto_pc = 1'b0; pc_in = 32'h6;
        #1;
        n_cmp++; if (misaligned !== 1'b1) begin n_bad++; $display("FAIL err_misaligned got %b want 1", misaligned); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL err_mis_req got %b want 0", imem_req); end
        step();
        n_cmp++; if (acc_count != 0) begin n_bad++; $display("FAIL err_mis_accepts got %0d want 0", acc_count); end
        force_rvalid = 1'b1;
        step();
        force_rvalid = 1'b0;
        n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL err_resp_err_set got %b want 1", resp_err); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL err_fifo_unchanged got %b want 0", id_valid); end
        step();
        step();
        n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL err_resp_err_sticky got %b want 1", resp_err); end
        rst = 1'b1;
        step();
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL err_resp_err_cleared got %b want 0", resp_err); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b0; auto_pc = 1'b1; pc_in = 32'h0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (id_valid !== 1'b1 || q_due.size() != 1) begin n_bad++; $display("FAIL rm_pre got v=%b inflight=%0d want v=1 inflight=1", id_valid, q_due.size()); end
        rst = 1'b1;
        step();
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %b want 0", id_valid); end
        n_cmp++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin n_bad++; $display("FAIL rm_data got instr=%h pc=%h want 0 0", id_instr, id_pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req got %b want 0", imem_req); end
        rst = 1'b0;
        imem_gnt = 1'b0;
        step();
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rm_resp_err got %b want 0", resp_err); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rm_after_valid got %b want 0", id_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_bad++; $display("FAIL rm_credits got req=%b addr=%h want 1 10", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_grant_stall();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
